// File: rtl/csr_if.sv
// CSR register-file bus: access port from the read-modify-write unit, trap and
// MRET controls, interrupt lines, and the architectural state outputs.
// master = upstream unit / bench, slave = csr_regfile.
interface csr_if;
  logic [11:0] csr_addr;
  logic [31:0] csr_rdata;
  logic        csr_addr_invalid;
  logic        csr_wen;
  logic [31:0] csr_wdata;
  logic        trap_valid;
  logic [31:0] trap_cause;
  logic [31:0] trap_pc;
  logic [31:0] trap_tval;
  logic        mret_valid;
  logic        instr_retire;
  logic        ext_irq;
  logic        tmr_irq;
  logic        sw_irq;
  logic [1:0]  current_mode;
  logic [31:0] mtvec_out;
  logic [31:0] mepc_out;
  logic        irq_pending;

  modport master (
    output csr_addr, csr_wen, csr_wdata,
    output trap_valid, trap_cause, trap_pc, trap_tval,
    output mret_valid, instr_retire, ext_irq, tmr_irq, sw_irq,
    input  csr_rdata, csr_addr_invalid, current_mode, mtvec_out, mepc_out, irq_pending
  );

  modport slave (
    input  csr_addr, csr_wen, csr_wdata,
    input  trap_valid, trap_cause, trap_pc, trap_tval,
    input  mret_valid, instr_retire, ext_irq, tmr_irq, sw_irq,
    output csr_rdata, csr_addr_invalid, current_mode, mtvec_out, mepc_out, irq_pending
  );
endinterface

// File: rtl/csr_regfile.sv
// Machine-mode CSR storage: architectural CSRs with combinational read,
// WARL write commit, trap entry, MRET return, privilege tracking and
// interrupt-pending evaluation.
// Build option: define CSR_COUNTERS_EN to implement the 64-bit mcycle/minstret
// counters; otherwise their addresses stay valid, read 0 and ignore writes.
module csr_regfile #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] HART_ID     = 32'd0,
  parameter logic [31:0] MISA_VAL    = 32'h4000_0100
) (
  input  logic clk,
  input  logic rst_n,
  csr_if.slave bus
);
  localparam logic [1:0]  MODE_M   = 2'b11;
  localparam logic [1:0]  MODE_U   = 2'b00;
  localparam logic [31:0] MIE_MASK = 32'h0000_0888;

  logic [1:0]  mode_q;
  logic        mstatus_mie;
  logic        mstatus_mpie;
  logic [1:0]  mstatus_mpp;
  logic [31:0] mie_q;
  logic [31:2] mtvec_q;
  logic [31:0] mscratch_q;
  logic [31:2] mepc_q;
  logic [31:0] mcause_q;
  logic [31:0] mtval_q;

  logic [31:0] mstatus_rd;
  logic [31:0] mip_rd;
  logic [31:0] rdata;
  logic        addr_invalid;
  logic        wr_commit;

  // A trap or MRET in the same cycle swallows the CSR write.
  assign wr_commit = bus.csr_wen & ~bus.trap_valid & ~bus.mret_valid;

  assign mstatus_rd = {19'b0, mstatus_mpp, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
  assign mip_rd     = {20'b0, bus.ext_irq, 3'b0, bus.tmr_irq, 3'b0, bus.sw_irq, 3'b0};

  // Architectural state: reset > trap > mret > csr write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q       <= MODE_M;
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mstatus_mpp  <= 2'b00;
      mie_q        <= '0;
      mtvec_q      <= MTVEC_RESET[31:2];
      mscratch_q   <= '0;
      mepc_q       <= '0;
      mcause_q     <= '0;
      mtval_q      <= '0;
    end else if (bus.trap_valid) begin
      mepc_q       <= bus.trap_pc[31:2];
      mcause_q     <= bus.trap_cause;
      mtval_q      <= bus.trap_tval;
      mstatus_mpie <= mstatus_mie;
      mstatus_mie  <= 1'b0;
      mstatus_mpp  <= mode_q;
      mode_q       <= MODE_M;
    end else if (bus.mret_valid) begin
      mode_q       <= mstatus_mpp;
      mstatus_mie  <= mstatus_mpie;
      mstatus_mpie <= 1'b1;
      mstatus_mpp  <= MODE_U;
    end else if (bus.csr_wen) begin
      case (bus.csr_addr)
        12'h300: begin
          mstatus_mie  <= bus.csr_wdata[3];
          mstatus_mpie <= bus.csr_wdata[7];
          // Only M and U exist; reserved encodings leave MPP untouched.
          if (bus.csr_wdata[12:11] == MODE_M || bus.csr_wdata[12:11] == MODE_U)
            mstatus_mpp <= bus.csr_wdata[12:11];
        end
        12'h304: mie_q      <= bus.csr_wdata & MIE_MASK;
        12'h305: mtvec_q    <= bus.csr_wdata[31:2];
        12'h340: mscratch_q <= bus.csr_wdata;
        12'h341: mepc_q     <= bus.csr_wdata[31:2];
        12'h342: mcause_q   <= bus.csr_wdata;
        12'h343: mtval_q    <= bus.csr_wdata;
        default: ;
      endcase
    end
  end

`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle_q;
  logic [63:0] minstret_q;

  // mcycle: free-running; a write to either half replaces it and skips the tick.
  always_ff @(posedge clk) begin
    if (!rst_n)
      mcycle_q <= '0;
    else if (wr_commit && bus.csr_addr == 12'hB00)
      mcycle_q <= {mcycle_q[63:32], bus.csr_wdata};
    else if (wr_commit && bus.csr_addr == 12'hB80)
      mcycle_q <= {bus.csr_wdata, mcycle_q[31:0]};
    else
      mcycle_q <= mcycle_q + 64'd1;
  end

  // minstret: counts retirements; a write to either half wins over the retire.
  always_ff @(posedge clk) begin
    if (!rst_n)
      minstret_q <= '0;
    else if (wr_commit && bus.csr_addr == 12'hB02)
      minstret_q <= {minstret_q[63:32], bus.csr_wdata};
    else if (wr_commit && bus.csr_addr == 12'hB82)
      minstret_q <= {bus.csr_wdata, minstret_q[31:0]};
    else if (bus.instr_retire)
      minstret_q <= minstret_q + 64'd1;
  end
`else
  logic unused_cnt;
  assign unused_cnt = bus.instr_retire ^ wr_commit;
`endif

  // Zero-latency read decode; unknown addresses read 0 and flag invalid.
  always_comb begin
    rdata        = '0;
    addr_invalid = 1'b0;
    case (bus.csr_addr)
      12'h300: rdata = mstatus_rd;
      12'h301: rdata = MISA_VAL;
      12'h304: rdata = mie_q;
      12'h305: rdata = {mtvec_q, 2'b00};
      12'h340: rdata = mscratch_q;
      12'h341: rdata = {mepc_q, 2'b00};
      12'h342: rdata = mcause_q;
      12'h343: rdata = mtval_q;
      12'h344: rdata = mip_rd;
      12'hF14: rdata = HART_ID;
`ifdef CSR_COUNTERS_EN
      12'hB00, 12'hC00: rdata = mcycle_q[31:0];
      12'hB80, 12'hC80: rdata = mcycle_q[63:32];
      12'hB02, 12'hC02: rdata = minstret_q[31:0];
      12'hB82, 12'hC82: rdata = minstret_q[63:32];
`else
      12'hB00, 12'hC00, 12'hB80, 12'hC80,
      12'hB02, 12'hC02, 12'hB82, 12'hC82: rdata = '0;
`endif
      default: addr_invalid = 1'b1;
    endcase
  end

  assign bus.csr_rdata        = rdata;
  assign bus.csr_addr_invalid = addr_invalid;
  assign bus.current_mode     = mode_q;
  assign bus.mtvec_out        = {mtvec_q, 2'b00};
  assign bus.mepc_out         = {mepc_q, 2'b00};
  // Interrupts are taken in M only when MIE is set, always when below M.
  assign bus.irq_pending      = (|(mip_rd & mie_q)) & (mstatus_mie | (mode_q != MODE_M));
endmodule

// File: tb/tb_csr_regfile.sv
// Self-checking bench for csr_regfile: expected observations are queued as
// stimulus is applied and compared once the DUT output has settled.
module tb_csr_regfile;
  localparam logic [31:0] MTVEC_RST = 32'h8000_0103;
  localparam logic [31:0] MTVEC_EXP = 32'h8000_0100;
  localparam logic [31:0] HART      = 32'd5;
  localparam logic [31:0] MISA      = 32'h4000_0100;

  localparam int K_RDATA = 0;
  localparam int K_INV   = 1;
  localparam int K_MODE  = 2;
  localparam int K_IRQ   = 3;
  localparam int K_MTVEC = 4;
  localparam int K_MEPC  = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       tag;
  } sb_t;
  sb_t sbq[$];

  csr_if bus();

  csr_regfile #(
    .MTVEC_RESET(MTVEC_RST),
    .HART_ID    (HART),
    .MISA_VAL   (MISA)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #50 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] obs(input int kind);
    case (kind)
      K_RDATA: return bus.csr_rdata;
      K_INV:   return {31'b0, bus.csr_addr_invalid};
      K_MODE:  return {30'b0, bus.current_mode};
      K_IRQ:   return {31'b0, bus.irq_pending};
      K_MTVEC: return bus.mtvec_out;
      default: return bus.mepc_out;
    endcase
  endfunction

  task automatic drain();
    sb_t it;
    while (sbq.size() > 0) begin
      it = sbq.pop_front();
      chk(it.tag, obs(it.kind), it.exp);
    end
  endtask

  task automatic expect_o(input int kind, input logic [11:0] addr,
                          input logic [31:0] exp, input string tag);
    bus.csr_addr = addr;
    sbq.push_back('{kind, exp, tag});
    #1;
    drain();
  endtask

  task automatic rd(input logic [11:0] addr, input logic [31:0] exp, input string tag);
    expect_o(K_RDATA, addr, exp, tag);
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic [11:0] addr, input logic [31:0] data);
    bus.csr_addr  = addr;
    bus.csr_wen   = 1'b1;
    bus.csr_wdata = data;
    cyc();
    bus.csr_wen   = 1'b0;
  endtask

  task automatic trap(input logic [31:0] cause, input logic [31:0] pc, input logic [31:0] tval);
    bus.trap_valid = 1'b1;
    bus.trap_cause = cause;
    bus.trap_pc    = pc;
    bus.trap_tval  = tval;
    cyc();
    bus.trap_valid = 1'b0;
    bus.csr_wen    = 1'b0;
    bus.mret_valid = 1'b0;
  endtask

  initial begin
    bus.csr_addr = 12'h000; bus.csr_wen = 1'b0; bus.csr_wdata = '0;
    bus.trap_valid = 1'b0; bus.trap_cause = '0; bus.trap_pc = '0; bus.trap_tval = '0;
    bus.mret_valid = 1'b0; bus.instr_retire = 1'b0;
    bus.ext_irq = 1'b0; bus.tmr_irq = 1'b0; bus.sw_irq = 1'b0;

    // Reset state
    @(negedge clk);
    cyc();
    cyc();
    rst_n = 1'b1;
    rd(12'h305, MTVEC_EXP, "rst_mtvec");
    rd(12'hF14, HART, "rst_hartid");
    rd(12'h301, MISA, "rst_misa");
    rd(12'h300, 32'h0, "rst_mstatus");
    expect_o(K_MODE, 12'h300, 32'd3, "rst_mode");
    expect_o(K_IRQ, 12'h300, 32'd0, "rst_irq");
    expect_o(K_MEPC, 12'h300, 32'd0, "rst_mepc_out");
    expect_o(K_MTVEC, 12'h300, MTVEC_EXP, "rst_mtvec_out");

    // mstatus WARL
    wr(12'h300, 32'hFFFF_FFFF);
    rd(12'h300, 32'h0000_1888, "mstatus_all1");
    wr(12'h300, 32'h0000_1000);
    rd(12'h300, 32'h0000_1800, "mstatus_mpp_rsvd");

    // Trap with MIE=1 in M, same-cycle mscratch write dropped
    wr(12'h300, 32'h0000_1808);
    wr(12'h340, 32'hA5A5_0001);
    rd(12'h340, 32'hA5A5_0001, "mscratch_wr");
    bus.csr_addr = 12'h340; bus.csr_wen = 1'b1; bus.csr_wdata = 32'h0000_1111;
    trap(32'd2, 32'h0000_1236, 32'h0000_DEAD);
    rd(12'h341, 32'h0000_1234, "trap_mepc");
    expect_o(K_MEPC, 12'h341, 32'h0000_1234, "trap_mepc_out");
    rd(12'h342, 32'd2, "trap_mcause");
    rd(12'h343, 32'h0000_DEAD, "trap_mtval");
    rd(12'h300, 32'h0000_1880, "trap_mstatus");
    rd(12'h340, 32'hA5A5_0001, "trap_mscratch_kept");
    expect_o(K_MODE, 12'h300, 32'd3, "trap_mode");

    // MRET to U, same-cycle write dropped
    wr(12'h300, 32'h0000_0080);
    rd(12'h300, 32'h0000_0080, "pre_mret_mstatus");
    bus.mret_valid = 1'b1;
    bus.csr_addr = 12'h340; bus.csr_wen = 1'b1; bus.csr_wdata = 32'h0000_2222;
    cyc();
    bus.mret_valid = 1'b0; bus.csr_wen = 1'b0;
    expect_o(K_MODE, 12'h300, 32'd0, "mret_mode");
    rd(12'h300, 32'h0000_0088, "mret_mstatus");
    rd(12'h340, 32'hA5A5_0001, "mret_mscratch_kept");

    // Interrupt pending
    wr(12'h304, 32'h0000_0080);
    bus.tmr_irq = 1'b1;
    expect_o(K_IRQ, 12'h304, 32'd1, "irq_tmr_umode");
    rd(12'h344, 32'h0000_0080, "mip_tmr");

    // Trap from U: MPP=U, MIE cleared, so irq masked in M
    trap(32'h8000_0007, 32'h0000_2003, 32'h0);
    expect_o(K_MODE, 12'h300, 32'd3, "trapU_mode");
    rd(12'h300, 32'h0000_0080, "trapU_mstatus");
    rd(12'h341, 32'h0000_2000, "trapU_mepc");
    rd(12'h342, 32'h8000_0007, "trapU_mcause");
    expect_o(K_IRQ, 12'h300, 32'd0, "irq_masked_m");
    wr(12'h300, 32'h0000_0008);
    expect_o(K_IRQ, 12'h300, 32'd1, "irq_mie_m");
    bus.tmr_irq = 1'b0; bus.ext_irq = 1'b1;
    expect_o(K_IRQ, 12'h344, 32'd0, "irq_ext_disabled");
    rd(12'h344, 32'h0000_0800, "mip_ext");
    wr(12'h304, 32'hFFFF_FFFF);
    rd(12'h304, 32'h0000_0888, "mie_mask");
    expect_o(K_IRQ, 12'h304, 32'd1, "irq_ext_enabled");
    bus.ext_irq = 1'b0;

    // Trap beats MRET in the same cycle
    bus.mret_valid = 1'b1;
    trap(32'd11, 32'h0000_3000, 32'h0);
    expect_o(K_MODE, 12'h300, 32'd3, "trap_over_mret_mode");
    rd(12'h300, 32'h0000_1880, "trap_over_mret_mstatus");

    // Unimplemented address
    rd(12'h7C0, 32'h0, "inv_rdata");
    expect_o(K_INV, 12'h7C0, 32'd1, "inv_flag");
    expect_o(K_INV, 12'h300, 32'd0, "valid_flag");
    wr(12'h7C0, 32'hFFFF_FFFF);
    rd(12'h340, 32'hA5A5_0001, "inv_wr_mscratch");
    rd(12'h300, 32'h0000_1880, "inv_wr_mstatus");
    rd(12'h304, 32'h0000_0888, "inv_wr_mie");
    rd(12'h341, 32'h0000_3000, "inv_wr_mepc");
    rd(12'h305, MTVEC_EXP, "inv_wr_mtvec");

    // Other WARL / read-only registers
    wr(12'h305, 32'h1234_5677);
    rd(12'h305, 32'h1234_5674, "mtvec_warl");
    expect_o(K_MTVEC, 12'h305, 32'h1234_5674, "mtvec_out");
    wr(12'h301, 32'h0);
    rd(12'h301, MISA, "misa_ro");
    wr(12'hF14, 32'h0);
    rd(12'hF14, HART, "hartid_ro");
    bus.sw_irq = 1'b1;
    wr(12'h344, 32'h0);
    rd(12'h344, 32'h0000_0008, "mip_ro");
    bus.sw_irq = 1'b0;

`ifdef CSR_COUNTERS_EN
    // mcycle low-half wrap carries into high half
    wr(12'hB00, 32'hFFFF_FFFF);
    wr(12'hB80, 32'h0);
    rd(12'hB00, 32'hFFFF_FFFF, "mcycle_wr_lo");
    rd(12'hB80, 32'h0, "mcycleh_wr");
    cyc();
    rd(12'hB00, 32'h0, "mcycle_wrap");
    rd(12'hB80, 32'h1, "mcycleh_carry");
    rd(12'hC80, 32'h1, "cycleh_shadow");
    // write beats retire increment
    bus.instr_retire = 1'b1;
    wr(12'hB02, 32'h0000_0055);
    rd(12'hB02, 32'h0000_0055, "minstret_wr");
    cyc(); cyc(); cyc();
    bus.instr_retire = 1'b0;
    cyc();
    rd(12'hB02, 32'h0000_0058, "minstret_cnt");
    rd(12'hC02, 32'h0000_0058, "instret_shadow");
    rd(12'hB82, 32'h0, "minstreth");
`else
    rd(12'hB00, 32'h0, "mcycle_absent");
    expect_o(K_INV, 12'hB00, 32'd0, "mcycle_addr_valid");
    wr(12'hB02, 32'h0000_1234);
    rd(12'hB02, 32'h0, "minstret_absent");
    expect_o(K_INV, 12'hC82, 32'd0, "instreth_addr_valid");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/csr_regfile.md
Name: csr_regfile

Overview:
- Machine-mode CSR storage stage, directly downstream of the CSR read-modify-write unit.
- Holds the architectural CSRs and drives their current value combinationally, as csr_rdata, into that unit.
- Commits the unit's computed new value when the write is legal.
- Also performs trap entry, MRET return, privilege-mode tracking, cycle/instret counting and interrupt-pending evaluation.

Parameters:
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec (low 2 bits forced 0).
- HART_ID, 0, value returned by mhartid (0xF14).
- MISA_VAL, 32'h4000_0100, read-only misa value (RV32I).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- csr_addr  in  12  CSR address being accessed this cycle.
- csr_rdata  out  32  combinational read of csr_addr; feeds the unit's csr_reg input.
- csr_addr_invalid  out  1  combinational; 1 when csr_addr is not implemented.
- csr_wen  in  1  commit csr_wdata to csr_addr (system & ~illegal_csr & retiring).
- csr_wdata  in  32  new value (the unit's csr_new).
- trap_valid  in  1  take trap this cycle.
- trap_cause  in  32  mcause value; bit31 set = interrupt.
- trap_pc  in  32  faulting/interrupted PC.
- trap_tval  in  32  mtval value.
- mret_valid  in  1  execute MRET.
- instr_retire  in  1  one instruction retired this cycle.
- ext_irq, tmr_irq, sw_irq  in  1 each  level interrupt lines → mip.MEIP/MTIP/MSIP.
- current_mode  out  2  privilege mode (2'b11 M, 2'b00 U).
- mtvec_out  out  32  trap target.
- mepc_out  out  32  MRET target.
- irq_pending  out  1  enabled interrupt pending and globally enabled.

Behaviour:
- Reset (rst_n=0 at a rising edge, overrides every other input that cycle):
  - current_mode=2'b11; mstatus=0; mie=0; mscratch=0; mepc=0; mcause=0; mtval=0.
  - mtvec=MTVEC_RESET; counters=0.
  - Outputs follow from that state: irq_pending=0, mepc_out=0, mtvec_out=MTVEC_RESET.
- Implemented addresses:
  - 0x300 mstatus, 0x301 misa, 0x304 mie, 0x305 mtvec, 0x340 mscratch, 0x341 mepc, 0x342 mcause, 0x343 mtval, 0x344 mip.
  - 0xB00/0xB80 mcycle/h, 0xB02/0xB82 minstret/h.
  - 0xC00/0xC80/0xC02/0xC82 user shadows, 0xF14 mhartid.
  - Any other address: csr_rdata=0, csr_addr_invalid=1, writes ignored.
- Read: zero latency, combinational. A write committed at edge N is visible on csr_rdata from cycle N+1.
- WARL / hardwired fields:
  - mstatus keeps only MIE[3], MPIE[7], MPP[12:11]. A write of MPP=2'b01 or 2'b10 keeps the old MPP. Other bits read 0.
  - mtvec[1:0] and mepc[1:0] read 0 (direct mode only).
  - mie keeps bits 3, 7, 11; others read 0.
  - mip reads {ext_irq<<11 | tmr_irq<<7 | sw_irq<<3} and ignores writes.
  - misa, mhartid and 0xCxx shadows ignore writes.
- Update priority per edge: reset > trap_valid > mret_valid > csr_wen.
- Trap entry:
  - mepc←{trap_pc[31:2],2'b00}; mcause←trap_cause; mtval←trap_tval.
  - MPIE←MIE; MIE←0; MPP←current_mode; current_mode←2'b11.
  - Any same-cycle csr_wen is dropped.
- MRET: current_mode←MPP; MIE←MPIE; MPIE←1; MPP←2'b00. Any same-cycle csr_wen is dropped.
- Counters: 64-bit.
  - mcycle increments every cycle; minstret increments when instr_retire=1.
  - A csr_wen to the low or high half replaces that half with csr_wdata, leaves the other half unchanged, and suppresses that counter's increment that cycle.
  - Wrap 2^64−1→0; low-half wrap carries into the high half.
- irq_pending = (|(mip & mie)) & (MIE | current_mode!=2'b11), combinational.

Optional Feature:
- Macro CSR_COUNTERS_EN.
- Defined: the 64-bit mcycle/minstret counters and their shadows are implemented as above.
- Undefined: no counter flops. Counter addresses remain valid (csr_addr_invalid=0), read 0, and ignore writes.

Test Plan:
- Reset, then read 0x305 and 0xF14 → csr_rdata=MTVEC_RESET and HART_ID; current_mode=2'b11; irq_pending=0.
- csr_wen to 0x300 with 32'hFFFF_FFFF → next-cycle read 0x300 = 32'h0000_1888; a following write with MPP=2'b10 → MPP stays 2'b11.
- MIE=1, mode M, trap_valid with trap_pc=32'h0000_1236, cause=2, plus same-cycle csr_wen to 0x340 → mepc=32'h0000_1234, mcause=2, MIE=0, MPIE=1, mscratch unchanged.
- MPP=2'b00, MPIE=1, mret_valid → current_mode=2'b00, MIE=1, MPP=2'b00; then mie=32'h80 with tmr_irq=1 → irq_pending=1.
- (CSR_COUNTERS_EN) write mcycle=32'hFFFF_FFFF, mcycleh=0 → two cycles later mcycleh=1 and mcycle=0; csr_wen to 0xB02 with instr_retire=1 → minstret equals the written value, not +1.
- Read 0x7C0 → csr_rdata=0, csr_addr_invalid=1; a csr_wen to 0x7C0 leaves all other CSRs unchanged.
